validatecount_sched: RTL and testbench
======================================

// Module: validatecount_sched
// PURPOSE
//  Shares one hysteresis/validation engine among NCH video-timing measurement channels
//  (e.g. h-sync width, h-total, v-sync width, v-total).
//  Each channel posts a raw measurement with a strobe; a scheduler grants one pending
//  channel per cycle to a 2-stage pipelined update engine.
//  Per-channel state: reference value and confidence count.
//  A channel's output becomes valid only after 2**NGB-1 net agreeing samples.
//  Sits between the raw video-timing counters and the mode-detect/register bus logic.
// PARAMETERS
//  NBITS  16  width of each measurement value
//  NCH    4   number of measurement channels (2..8)
//  NGB    3   confidence counter width; locked when count == 2**NGB-1
// PORTS
//  i_clk      in   1          system clock
//  i_reset    in   1          asynchronous, active-high reset
//  i_v        in   NCH        per-channel sample strobe, one-cycle pulse
//  i_val      in   NCH*NBITS  channel k value at [k*NBITS +: NBITS]
//  o_val      out  NCH*NBITS  validated value per channel, same packing
//  o_locked   out  NCH        channel confidence saturated
//  o_overrun  out  NCH        1-cycle pulse: new sample overwrote an ungranted pending one
//  o_busy     out  1          any channel pending or update stage occupied
// BEHAVIOUR
//  Reset (async, asserted high)
//   - Clears pend, pend_val, ref, cnt, the stage register and all outputs to 0.
//   - Reset in mid-operation discards in-flight samples; no update completes after it.
//  Capture
//   - i_v[k] at edge t: pend_val[k] <= i_val[k], pend[k] <= 1.
//   - If pend[k] was already 1 and not granted that cycle: o_overrun[k]=1 for one cycle; newest value wins.
//  Grant (combinational from pend, registered into stage S1 at each edge)
//   - Round-robin: search starts at the channel after the last granted one.
//   - S1 <= {valid,k,pend_val[k]}; pend[k] cleared unless i_v[k] in the same cycle, in which case it stays set with the new value.
//  Update (edge after S1 valid), using the current registered cnt[k]/ref[k]
//   - cnt==0: ref<=val, cnt<=1.
//   - val==ref: cnt<=cnt+1, saturating at 2**NGB-1.
//   - else: cnt<=cnt-1.
//   - Output rule, applied to the new cnt: if new cnt==max, o_val[k]<=ref (new) and o_locked[k]<=1;
//     if new cnt==0, o_val[k]<=0 and o_locked[k]<=0; otherwise hold both.
//  Ordering and latency
//   - Back-to-back updates to the same channel are hazard-free: each update reads the state written at the prior edge.
//   - Latency, uncontended: i_v at edge t -> S1 at t+1 -> state/outputs at t+2.
//   - Throughput: 1 update/cycle; worst-case grant wait NCH-1 cycles.
//  Widths: compare is full NBITS equality; no arithmetic on values.
//  o_busy = |pend | S1.valid.
// CONFIGURATION
//  VALIDATE_FIXED_PRIO_EN
//   - Defined: fixed priority, lowest index wins; round-robin pointer removed.
//   - Undefined (default): round-robin as above.
// TESTING
//  1. Reset; ch0 pulses 0x0320 on 7 spaced strobes -> o_locked[0]=1 and o_val[0]=0x0320
//     two cycles after the 7th strobe; o_val[0]=0 before that.
//  2. Ch0 locked at 0x0320, then 7 strobes of 0x0321 -> o_locked[0] drops after the 1st,
//     o_val[0] holds 0x0320 until cnt=0 (7th), then 0; the next 7 strobes of 0x0321 lock 0x0321.
//  3. All 4 channels strobe in the same cycle, 8 times -> each granted once per 4 cycles;
//     no o_overrun; all lock to their values.
//  4. Ch2 strobes 0x0010 then 0x0020 in consecutive cycles while ch0/ch1 pending -> o_overrun[2] pulse;
//     only 0x0020 is applied.
//  5. Assert i_reset asynchronously while S1 valid -> all outputs 0 immediately; o_busy=0; no late update.
//  6. VALIDATE_FIXED_PRIO_EN defined, ch0 strobes every cycle, ch3 once -> ch3 never granted;
//     o_busy stays 1 (starvation is the intended behaviour).

Source files
------------

// File: rtl/validatecount_sched.sv
`default_nettype none
// ============================================================================
// Module   : validatecount_sched
// Purpose  : One shared hysteresis/validation engine serving NCH video-timing
//            measurement channels. Each channel posts a raw sample with a
//            strobe. A scheduler grants one pending channel per cycle into a
//            2-stage update pipeline. That pipeline keeps a reference value
//            and a confidence count for each channel. A channel's output
//            becomes valid once the count saturates at 2**NGB-1.
// Ports    : i_clk      system clock
//            i_reset    asynchronous, active-high reset
//            i_v        per-channel one-cycle sample strobe
//            i_val      channel k sample at [k*NBITS +: NBITS]
//            o_val      validated value per channel, same packing
//            o_locked   channel confidence saturated
//            o_overrun  1-cycle pulse: ungranted pending sample overwritten
//            o_busy     any channel pending or update stage occupied
// Options  : VALIDATE_FIXED_PRIO_EN - fixed priority (lowest index wins)
//            instead of round-robin arbitration.
// Revision : 1.0  initial release
// ============================================================================
module validatecount_sched #(
    parameter int NBITS = 16,
    parameter int NCH   = 4,
    parameter int NGB   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NCH-1:0]       i_v,
    input  logic [NCH*NBITS-1:0] i_val,
    output logic [NCH*NBITS-1:0] o_val,
    output logic [NCH-1:0]       o_locked,
    output logic [NCH-1:0]       o_overrun,
    output logic                 o_busy
);

    localparam int             c_cw      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [NGB-1:0] c_cnt_max = {NGB{1'b1}};

    // Pending sample per channel
    logic [NCH-1:0]   r_pend;
    logic [NBITS-1:0] r_pend_val [NCH];

    // Stage S1: granted sample on its way to the update engine
    logic             r_s1_v;
    logic [c_cw-1:0]  r_s1_ch;
    logic [NBITS-1:0] r_s1_val;

    // Per-channel validation state and outputs
    logic [NBITS-1:0] r_ref  [NCH];
    logic [NGB-1:0]   r_cnt  [NCH];
    logic [NBITS-1:0] r_oval [NCH];
    logic [NCH-1:0]   r_locked;
    logic [NCH-1:0]   r_overrun;

    // Grant
    logic             w_gnt_valid;
    logic [c_cw-1:0]  w_gnt_idx;
    logic [NCH-1:0]   w_gnt_onehot;
    logic [NCH-1:0]   w_search;

`ifdef VALIDATE_FIXED_PRIO_EN
    always_comb begin
        w_search = r_pend;
    end
`else
    logic [c_cw-1:0] r_last;
    logic [NCH-1:0]  w_mask;

    // Round-robin: prefer pending channels above the last grant, otherwise
    // wrap around to the lowest pending channel.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NCH; k++) begin
            w_mask[k] = (k > int'(r_last));
        end
        w_search = ((r_pend & w_mask) != '0) ? (r_pend & w_mask) : r_pend;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // Start just below channel 0 so the first search begins at 0
            r_last <= c_cw'(NCH - 1);
        end else if (w_gnt_valid) begin
            r_last <= w_gnt_idx;
        end
    end
`endif

    always_comb begin
        w_gnt_valid  = |r_pend;
        w_gnt_idx    = '0;
        w_gnt_onehot = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_search[k]) begin
                w_gnt_idx = c_cw'(k);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            w_gnt_onehot[k] = w_gnt_valid && (w_gnt_idx == c_cw'(k));
        end
    end

    // Capture, grant and overrun detection
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend    <= '0;
            r_overrun <= '0;
            r_s1_v    <= 1'b0;
            r_s1_ch   <= '0;
            r_s1_val  <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_pend_val[k] <= '0;
            end
        end else begin
            r_s1_v   <= w_gnt_valid;
            r_s1_ch  <= w_gnt_idx;
            r_s1_val <= r_pend_val[w_gnt_idx];
            for (int k = 0; k < NCH; k++) begin
                // A strobe on the channel being granted keeps it pending
                // with the new value; the granted copy already left.
                if (i_v[k]) begin
                    r_pend_val[k] <= i_val[k*NBITS +: NBITS];
                    r_pend[k]     <= 1'b1;
                end else if (w_gnt_onehot[k]) begin
                    r_pend[k]     <= 1'b0;
                end
                r_overrun[k] <= i_v[k] & r_pend[k] & ~w_gnt_onehot[k];
            end
        end
    end

    // Update engine: next count/reference for the channel in S1
    logic [NGB-1:0]   w_cur_cnt;
    logic [NBITS-1:0] w_cur_ref;
    logic [NGB-1:0]   w_new_cnt;
    logic [NBITS-1:0] w_new_ref;

    always_comb begin
        w_cur_cnt = r_cnt[r_s1_ch];
        w_cur_ref = r_ref[r_s1_ch];
        w_new_cnt = w_cur_cnt;
        w_new_ref = w_cur_ref;
        if (w_cur_cnt == '0) begin
            w_new_ref = r_s1_val;
            w_new_cnt = NGB'(1);
        end else if (r_s1_val == w_cur_ref) begin
            if (w_cur_cnt != c_cnt_max) begin
                w_new_cnt = w_cur_cnt + 1'b1;
            end
        end else begin
            w_new_cnt = w_cur_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_locked <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_ref[k]  <= '0;
                r_cnt[k]  <= '0;
                r_oval[k] <= '0;
            end
        end else if (r_s1_v) begin
            r_cnt[r_s1_ch] <= w_new_cnt;
            r_ref[r_s1_ch] <= w_new_ref;
            // Locked tracks saturation exactly; the value only changes on
            // reaching saturation (new reference) or zero (cleared) and
            // otherwise keeps the last validated value.
            r_locked[r_s1_ch] <= (w_new_cnt == c_cnt_max);
            if (w_new_cnt == c_cnt_max) begin
                r_oval[r_s1_ch] <= w_new_ref;
            end else if (w_new_cnt == '0) begin
                r_oval[r_s1_ch] <= '0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_pack
            assign o_val[k*NBITS +: NBITS] = r_oval[k];
        end
    endgenerate

    assign o_locked  = r_locked;
    assign o_overrun = r_overrun;
    assign o_busy    = (|r_pend) | r_s1_v;

endmodule
`default_nettype wire

// File: tb/tb_validatecount_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_validatecount_sched
// Purpose  : Self-checking bench for validatecount_sched. Runs directed
//            scenarios and randomized strobes, comparing every cycle against
//            a behavioural model of the channels.
// Revision : 1.0  initial release
// ============================================================================
module tb_validatecount_sched;

    localparam int NBITS = 16;
    localparam int NCH   = 4;
    localparam int NGB   = 3;
    localparam int MAXC  = (1 << NGB) - 1;

    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       i_v;
    logic [NCH*NBITS-1:0] i_val;
    logic [NCH*NBITS-1:0] o_val;
    logic [NCH-1:0]       o_locked;
    logic [NCH-1:0]       o_overrun;
    logic                 o_busy;

    int n_checks = 0;
    int n_errors = 0;

    validatecount_sched #(.NBITS(NBITS), .NCH(NCH), .NGB(NGB)) u_dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_v       (i_v),
        .i_val     (i_val),
        .o_val     (o_val),
        .o_locked  (o_locked),
        .o_overrun (o_overrun),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_pend [NCH];
    logic [15:0] m_pval [NCH];
    logic [15:0] m_ref  [NCH];
    int          m_cnt  [NCH];
    logic [15:0] m_out  [NCH];
    bit          m_ovr  [NCH];
    bit          m_st_v;
    int          m_st_ch;
    logic [15:0] m_st_val;
    int          m_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_pend[k] = 0; m_pval[k] = '0; m_ref[k] = '0;
            m_cnt[k] = 0;  m_out[k] = '0;  m_ovr[k] = 0;
        end
        m_st_v = 0; m_st_ch = 0; m_st_val = '0;
        m_last = NCH - 1;
    endtask

    function automatic int pick();
        int g;
        g = -1;
`ifdef VALIDATE_FIXED_PRIO_EN
        for (int j = 0; j < NCH; j++)
            if (g < 0 && m_pend[j]) g = j;
`else
        for (int s = 1; s <= NCH; s++)
            if (g < 0 && m_pend[(m_last + s) % NCH]) g = (m_last + s) % NCH;
`endif
        return g;
    endfunction

    // One clock edge worth of behaviour, from the state before the edge
    task automatic model_step(input logic [NCH-1:0] v, input logic [NCH*NBITS-1:0] val);
        int ch;
        int g;
        if (m_st_v) begin
            ch = m_st_ch;
            if (m_cnt[ch] == 0) begin
                m_ref[ch] = m_st_val;
                m_cnt[ch] = 1;
            end else if (m_st_val == m_ref[ch]) begin
                m_cnt[ch] = (m_cnt[ch] < MAXC) ? m_cnt[ch] + 1 : MAXC;
            end else begin
                m_cnt[ch] = m_cnt[ch] - 1;
            end
            if (m_cnt[ch] == MAXC) m_out[ch] = m_ref[ch];
            else if (m_cnt[ch] == 0) m_out[ch] = '0;
        end
        g = pick();
        m_st_v = (g >= 0);
        if (g >= 0) begin
            m_st_ch  = g;
            m_st_val = m_pval[g];
            m_last   = g;
        end
        for (int k = 0; k < NCH; k++) begin
            m_ovr[k] = v[k] && m_pend[k] && (g != k);
            if (v[k]) begin
                m_pend[k] = 1;
                m_pval[k] = val[k*NBITS +: NBITS];
            end else if (g == k) begin
                m_pend[k] = 0;
            end
        end
    endtask

    task automatic compare_all(input string where);
        logic [63:0]    ev;
        logic [NCH-1:0] el, eo;
        bit             eb;
        eb = m_st_v;
        for (int k = 0; k < NCH; k++) begin
            ev[k*NBITS +: NBITS] = m_out[k];
            el[k] = (m_cnt[k] == MAXC);
            eo[k] = m_ovr[k];
            eb    = eb | m_pend[k];
        end
        chk({where, "_val"},  o_val, ev);
        chk({where, "_lock"}, 64'(o_locked), 64'(el));
        chk({where, "_ovr"},  64'(o_overrun), 64'(eo));
        chk({where, "_busy"}, 64'(o_busy), 64'(eb));
    endtask

    task automatic cycle(input string where, input logic [NCH-1:0] v, input logic [NCH*NBITS-1:0] val);
        i_v   = v;
        i_val = val;
        @(posedge clk);
        model_step(v, val);
        #1;
        i_v   = '0;
        i_val = '0;
        compare_all(where);
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) cycle(where, '0, '0);
    endtask

    function automatic logic [63:0] vals(input logic [15:0] v0, input logic [15:0] v1,
                                         input logic [15:0] v2, input logic [15:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    initial begin
        logic [NCH-1:0]       rv;
        logic [NCH*NBITS-1:0] rval;

        rst   = 1'b1;
        i_v   = '0;
        i_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val",  o_val, 64'h0);
        chk("rst_lock", 64'(o_locked), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        rst = 1'b0;

        // 1: ch0 locks to 0x0320 after seven agreeing samples
        for (int i = 0; i < 7; i++) begin
            cycle("t1", 4'b0001, vals(16'h0320, 0, 0, 0));
            idle("t1", 2);
            if (i < 6) begin
                chk("t1_val_early", 64'(o_val[15:0]), 64'h0);
                chk("t1_lock_early", 64'(o_locked[0]), 64'h0);
            end else begin
                chk("t1_val_lock", 64'(o_val[15:0]), 64'h0320);
                chk("t1_lock", 64'(o_locked[0]), 64'h1);
            end
        end
        idle("t1", 1);

        // 2: seven disagreeing samples unlock, seven more lock the new value
        for (int i = 0; i < 14; i++) begin
            cycle("t2", 4'b0001, vals(16'h0321, 0, 0, 0));
            idle("t2", 2);
            if (i == 0) chk("t2_unlock", 64'(o_locked[0]), 64'h0);
            if (i < 6)  chk("t2_hold", 64'(o_val[15:0]), 64'h0320);
            if (i == 6) chk("t2_clear", 64'(o_val[15:0]), 64'h0);
        end
        chk("t2_relock_val", 64'(o_val[15:0]), 64'h0321);
        chk("t2_relock", 64'(o_locked[0]), 64'h1);

        // 3: all channels strobe together, fair service, no overrun
        for (int i = 0; i < 8; i++) begin
            cycle("t3", 4'b1111, vals(16'h0321, 16'h1001, 16'h1002, 16'h1003));
            chk("t3_no_ovr", 64'(o_overrun), 64'h0);
            idle("t3", 3);
        end
        idle("t3", 3);
        chk("t3_all_lock", 64'(o_locked), 64'hF);
        chk("t3_vals", o_val, vals(16'h0321, 16'h1001, 16'h1002, 16'h1003));

        // 4: ch2 overwritten while ch0/ch1 are ahead of it
        cycle("t4", 4'b0111, vals(16'h0321, 16'h1001, 16'h0010, 0));
        cycle("t4", 4'b0100, vals(0, 0, 16'h0020, 0));
        chk("t4_ovr", 64'(o_overrun), 64'h4);
        idle("t4", 5);
        chk("t4_ovr_gone", 64'(o_overrun), 64'h0);

        // 5: asynchronous reset while S1 holds a sample
        cycle("t5", 4'b0010, vals(0, 16'h0777, 0, 0));
        cycle("t5", '0, '0);
        chk("t5_busy_pre", 64'(o_busy), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_val",  o_val, 64'h0);
        chk("t5_lock", 64'(o_locked), 64'h0);
        chk("t5_busy", 64'(o_busy), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("t5_after", 4);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NCH; k++) begin
                rv[k] = ($urandom_range(0, 2) == 0);
                rval[k*NBITS +: NBITS] = ($urandom_range(0, 9) == 0) ? 16'(16'h0200 + k) : 16'(16'h0100 + k);
            end
            cycle("rand", rv, rval);
        end
        idle("rand", 6);

`ifdef VALIDATE_FIXED_PRIO_EN
        // 6: ch0 hogs the engine, ch3 starves
        cycle("t6", 4'b1001, vals(16'h0321, 0, 0, 16'h0333));
        for (int i = 0; i < 20; i++) begin
            cycle("t6", 4'b0001, vals(16'h0321, 0, 0, 0));
            chk("t6_busy", 64'(o_busy), 64'h1);
        end
        idle("t6", 6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
